// File: rtl/anubis_key_sched_ctrl.sv
// ANUBIS key-schedule sequencer: emits kappa^0..kappa^ROUNDS over valid/ready and
// drives the external Psi evolution stage (load, EVO_CYCLES enabled steps, capture).
module anubis_key_sched_ctrl #(
   parameter int unsigned ROUNDS     = 12,
   parameter int unsigned EVO_CYCLES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] cipher_key,
   output logic         busy,
   output logic         done,
   output logic         evo_load_key,
   output logic         evo_clk_en,
   output logic [127:0] evo_key,
   output logic [127:0] evo_round_constant,
   input  logic [127:0] evo_result,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_index
);

   localparam int unsigned SW = (EVO_CYCLES > 1) ? $clog2(EVO_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, EMIT, LOAD, EVOLVE, CAPTURE} state_t;

   state_t        state, state_n;
   logic [3:0]    r, r_n;
   logic [127:0]  kappa, kappa_n;
   logic [SW-1:0] step, step_n;
   logic          handshake;
   logic          last;
   logic          evo_active;

   // Row 0 of c^r: gamma outputs S[4r-4..4r-1]; only indices 0..47 are ever addressed.
   function automatic logic [31:0] gamma_row(input logic [3:0] rr);
      logic [31:0] w;
      w = '0;
      case (rr)
         4'd1:    w = 32'ha7d3e671;
         4'd2:    w = 32'hd0ac4d79;
         4'd3:    w = 32'h3ac991fc;
         4'd4:    w = 32'h1e4754bd;
         4'd5:    w = 32'h8ca57afb;
         4'd6:    w = 32'h63b8ddd4;
         4'd7:    w = 32'he5b3c5be;
         4'd8:    w = 32'ha9880ca2;
         4'd9:    w = 32'h39df29da;
         4'd10:   w = 32'h2ba8cb4c;
         4'd11:   w = 32'h4b22aa24;
         4'd12:   w = 32'h4170a6f9;
         default: w = '0;
      endcase
      return w;
   endfunction

   always_comb begin
      state_n   = state;
      r_n       = r;
      kappa_n   = kappa;
      step_n    = step;
      handshake = (state == EMIT) && rk_ready;
      last      = handshake && (r == 4'(ROUNDS));
      unique case (state)
         IDLE: begin
            if (start) begin
               kappa_n = cipher_key;
               r_n     = '0;
               state_n = EMIT;
            end
         end
         EMIT: begin
            if (handshake) begin
               if (r == 4'(ROUNDS)) begin
                  state_n = IDLE;
               end else begin
                  r_n     = r + 4'd1;
                  state_n = LOAD;
               end
            end
         end
         LOAD: begin
            step_n  = '0;
            state_n = EVOLVE;
         end
         EVOLVE: begin
            if (step == SW'(EVO_CYCLES - 1)) begin
               state_n = CAPTURE;
            end else begin
               step_n = step + 1'b1;
            end
         end
         CAPTURE: begin
            kappa_n = evo_result;
            state_n = EMIT;
         end
         default: state_n = IDLE;
      endcase
      evo_active = (state_n == LOAD) || (state_n == EVOLVE) || (state_n == CAPTURE);
   end

   // Outputs are decoded from the next state so each registered output lines up with its state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         r                  <= '0;
         kappa              <= '0;
         step               <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
         evo_load_key       <= 1'b0;
         evo_clk_en         <= 1'b0;
         evo_key            <= '0;
         evo_round_constant <= '0;
         rk_valid           <= 1'b0;
         rk_data            <= '0;
         rk_index           <= '0;
      end else begin
         state              <= state_n;
         r                  <= r_n;
         kappa              <= kappa_n;
         step               <= step_n;
         busy               <= (state_n != IDLE);
         done               <= last;
         evo_load_key       <= (state_n == LOAD);
         evo_clk_en         <= (state_n == EVOLVE);
         evo_key            <= evo_active ? kappa_n : '0;
         evo_round_constant <= evo_active ? {gamma_row(r_n), 96'b0} : '0;
         rk_valid           <= (state_n == EMIT);
         rk_data            <= (state_n == EMIT) ? kappa_n : '0;
         rk_index           <= (state_n == EMIT) ? r_n : '0;
      end
   end

endmodule
